wb_port_scheduler: RTL and testbench
====================================

WB_PORT_SCHEDULER -- requirements
Module: wb_port_scheduler

Interface
REQ-001 SHALL have parameter DW, default 64, write-back data width.
REQ-002 SHALL have parameter DEPTH, default 2, ALU-result buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port AluValid  input  1  ALU result offered this cycle.
REQ-006 SHALL have port AluReady  output  1  scheduler accepts ALU result this cycle.
REQ-007 SHALL have port AluRd  input  5  ALU destination register.
REQ-008 SHALL have port ALUresult  input  DW  ALU result data.
REQ-009 SHALL have port LdValid  input  1  load data returning; no back-pressure possible.
REQ-010 SHALL have port LdRd  input  5  load destination register.
REQ-011 SHALL have port ReadData  input  DW  load data.
REQ-012 SHALL have port RegWrite  output  1  register-file write enable.
REQ-013 SHALL have port WriteReg  output  5  register-file write address.
REQ-014 SHALL have port WriteData  output  DW  register-file write data.
REQ-015 SHALL have port MemtoReg  output  1  source of current write: 1 load, 0 ALU.
REQ-016 SHALL have port ConflictCount  output  16  cycles an ALU write was deferred by a load, saturating.

Function
REQ-017 SHALL share one register-file write port between ALU and load sources; RegWrite/WriteReg/WriteData/MemtoReg registered, one cycle after winning selection.
REQ-018 SHALL give the load source absolute priority: LdValid with LdRd!=31 always wins the port.
REQ-019 SHALL accept an ALU result on AluValid&&AluReady; AluReady = (count < DEPTH), from registered count only.
REQ-020 SHALL bypass an accepted ALU result straight to the output register when buffer empty and no winning load; otherwise push it.
REQ-021 SHALL, when no winning load and buffer non-empty, pop the head (FIFO order) to the output; same-cycle push allowed, count unchanged.
REQ-022 SHALL never accept when full, even if popping the same cycle.
REQ-023 SHALL discard writes to register 31 (XZR): ALU entries accepted but not buffered, loads not written and port left free for ALU that cycle.
REQ-024 SHALL deassert RegWrite in any cycle with no winner; WriteReg/WriteData/MemtoReg then hold previous values.
REQ-025 SHALL increment ConflictCount each cycle a winning load is selected while buffer non-empty or ALU accept pending, saturating at 16'hFFFF.
REQ-026 SHALL write a load and a buffered ALU entry to the same rd in order load then ALU, so the ALU value is final.
REQ-027 SHALL wrap read/write pointers modulo DEPTH; count range 0..DEPTH.

Reset
REQ-028 SHALL on reset high at a clock edge: flush buffer (count 0, pointers 0), RegWrite 0, WriteReg 0, WriteData 0, MemtoReg 0, ConflictCount 0.
REQ-029 SHALL drive AluReady 1 in the first cycle after reset release.
REQ-030 SHALL drop any in-flight or buffered entry when reset is asserted mid-operation; nothing is written afterwards.

Structure
REQ-031 SHALL place REG_ADDR_W=5, XZR=5'd31, DW default and the source-select encoding in shared package wb_pkg.
REQ-032 SHALL implement the buffer as sub-module wb_fifo (parameterised DW+5 wide, DEPTH deep, push/pop/count).

Verification
REQ-033 ALU only: AluValid, AluRd=3, ALUresult=64'h11 -> next cycle RegWrite=1, WriteReg=3, WriteData=64'h11, MemtoReg=0.
REQ-034 Collision: same cycle LdValid LdRd=4 ReadData=64'hAA and ALU rd=5 64'hBB -> cycle+1 writes X4=AA (MemtoReg=1), cycle+2 writes X5=BB, ConflictCount=1.
REQ-035 Full: 3 consecutive loads with ALU offered every cycle -> AluReady low after 2 accepts; buffer drains in order after loads end.
REQ-036 XZR: LdRd=31 with ALU rd=7 64'h77 -> next cycle writes X7=77, no write to 31.
REQ-037 Same rd: load rd=9 64'h1 with buffered ALU rd=9 64'h2 -> X9 written 1 then 2.
REQ-038 Reset mid-drain: buffer holding 2 entries, reset one cycle -> RegWrite 0, no entry written after release, AluReady=1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and source-select encoding for the register-file write-back scheduler.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;
  localparam int unsigned DW_DEFAULT = 64;

  typedef enum logic [1:0] {
    SrcNone,
    SrcLoad,
    SrcFifo,
    SrcBypass
  } src_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO for deferred ALU results; pointers wrap modulo DEPTH, count spans 0..DEPTH.
module wb_fifo #(
  parameter int unsigned W     = 69,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not flushed; the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_port_scheduler.sv
// Arbitrates the single register-file write port between returning loads and ALU results.
module wb_port_scheduler
  import wb_pkg::*;
#(
  parameter int unsigned DW    = DW_DEFAULT,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  AluValid,
  output logic                  AluReady,
  input  logic [REG_ADDR_W-1:0] AluRd,
  input  logic [DW-1:0]         ALUresult,
  input  logic                  LdValid,
  input  logic [REG_ADDR_W-1:0] LdRd,
  input  logic [DW-1:0]         ReadData,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [DW-1:0]         WriteData,
  output logic                  MemtoReg,
  output logic [15:0]           ConflictCount
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = DW + REG_ADDR_W;

  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic          alu_keep, ld_win, empty, push, pop, conflict;
  src_sel_e      sel;

  always_comb begin
    AluReady = count < CW'(DEPTH);
    // XZR results are accepted but never occupy the buffer or the port.
    alu_keep = AluValid && AluReady && (AluRd != XZR);
    ld_win   = LdValid && (LdRd != XZR);
    empty    = count == '0;
    sel      = SrcNone;
    push     = 1'b0;
    pop      = 1'b0;
    if (ld_win) begin
      sel  = SrcLoad;
      push = alu_keep;
    end else if (!empty) begin
      sel  = SrcFifo;
      pop  = 1'b1;
      push = alu_keep;
    end else if (alu_keep) begin
      sel = SrcBypass;
    end
    conflict = ld_win && (!empty || alu_keep);
  end

  wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .wdata_i ({AluRd, ALUresult}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite      <= 1'b0;
      WriteReg      <= '0;
      WriteData     <= '0;
      MemtoReg      <= 1'b0;
      ConflictCount <= '0;
    end else begin
      RegWrite <= sel != SrcNone;
      // Address/data/source hold their previous values when nobody wins.
      case (sel)
        SrcLoad: begin
          WriteReg  <= LdRd;
          WriteData <= ReadData;
          MemtoReg  <= 1'b1;
        end
        SrcFifo: begin
          WriteReg  <= head[EW-1:DW];
          WriteData <= head[DW-1:0];
          MemtoReg  <= 1'b0;
        end
        SrcBypass: begin
          WriteReg  <= AluRd;
          WriteData <= ALUresult;
          MemtoReg  <= 1'b0;
        end
        default: ;
      endcase
      if (conflict && (ConflictCount != 16'hFFFF)) ConflictCount <= ConflictCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler with a cycle-accurate expected-write scoreboard.
module tb_wb_port_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        AluValid, AluReady, LdValid;
  logic [4:0]  AluRd, LdRd, WriteReg;
  logic [63:0] ALUresult, ReadData, WriteData;
  logic        RegWrite, MemtoReg;
  logic [15:0] ConflictCount;

  wb_port_scheduler #(
    .DW    (64),
    .DEPTH (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .AluValid      (AluValid),
    .AluReady      (AluReady),
    .AluRd         (AluRd),
    .ALUresult     (ALUresult),
    .LdValid       (LdValid),
    .LdRd          (LdRd),
    .ReadData      (ReadData),
    .RegWrite      (RegWrite),
    .WriteReg      (WriteReg),
    .WriteData     (WriteData),
    .MemtoReg      (MemtoReg),
    .ConflictCount (ConflictCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } entry_t;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic        m;
    logic [15:0] cc;
  } exp_t;

  entry_t      mq[$];
  exp_t        expq[$];
  logic [4:0]  last_wr;
  logic [63:0] last_wd;
  logic        last_m;
  logic [15:0] mconf;
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    expq.delete();
    last_wr = '0;
    last_wd = '0;
    last_m  = 1'b0;
    mconf   = '0;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
    exp_t   e, got;
    entry_t h;
    bit     ready, push, ldw;
    AluValid  = av;
    AluRd     = ard;
    ALUresult = ad;
    LdValid   = lv;
    LdRd      = lrd;
    ReadData  = ld;
    #3;
    ready = mq.size() < 2;
    chk("AluReady", {63'd0, AluReady}, {63'd0, ready});
    push = av && ready && (ard != 5'd31);
    ldw  = lv && (lrd != 5'd31);
    e.rw = 1'b1;
    if (ldw) begin
      last_wr = lrd;
      last_wd = ld;
      last_m  = 1'b1;
      if ((mq.size() != 0 || push) && mconf != 16'hFFFF) mconf = mconf + 16'd1;
      if (push) mq.push_back('{rd: ard, data: ad});
    end else if (mq.size() != 0) begin
      h       = mq.pop_front();
      last_wr = h.rd;
      last_wd = h.data;
      last_m  = 1'b0;
      if (push) mq.push_back('{rd: ard, data: ad});
    end else if (push) begin
      last_wr = ard;
      last_wd = ad;
      last_m  = 1'b0;
    end else begin
      e.rw = 1'b0;
    end
    e.wr = last_wr;
    e.wd = last_wd;
    e.m  = last_m;
    e.cc = mconf;
    expq.push_back(e);
    @(posedge clk);
    #1;
    got = expq.pop_front();
    chk("RegWrite",      {63'd0, RegWrite},      {63'd0, got.rw});
    chk("WriteReg",      {59'd0, WriteReg},      {59'd0, got.wr});
    chk("WriteData",     WriteData,              got.wd);
    chk("MemtoReg",      {63'd0, MemtoReg},      {63'd0, got.m});
    chk("ConflictCount", {48'd0, ConflictCount}, {48'd0, got.cc});
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  // One-cycle reset with live traffic on the inputs to show it is ignored.
  task automatic do_reset();
    reset     = 1'b1;
    AluValid  = 1'b1;
    AluRd     = 5'd6;
    ALUresult = 64'h66;
    LdValid   = 1'b1;
    LdRd      = 5'd6;
    ReadData  = 64'h67;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    chk("rst_RegWrite",      {63'd0, RegWrite},      64'd0);
    chk("rst_WriteReg",      {59'd0, WriteReg},      64'd0);
    chk("rst_WriteData",     WriteData,              64'd0);
    chk("rst_MemtoReg",      {63'd0, MemtoReg},      64'd0);
    chk("rst_ConflictCount", {48'd0, ConflictCount}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    model_clear();
    do_reset();

    // ALU only.
    step(1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 64'd0);
    idle();

    // Load collides with ALU: load first, ALU next, one conflict.
    step(1'b1, 5'd5, 64'hBB, 1'b1, 5'd4, 64'hAA);
    idle();
    idle();

    // Load to XZR leaves the port to the ALU.
    step(1'b1, 5'd7, 64'h77, 1'b1, 5'd31, 64'h99);
    idle();

    // ALU to XZR is swallowed.
    step(1'b1, 5'd31, 64'h55, 1'b0, 5'd0, 64'd0);

    // Three loads back to back with ALU always offered: buffer fills, then drains in order.
    step(1'b1, 5'd20, 64'h200, 1'b1, 5'd10, 64'h100);
    step(1'b1, 5'd21, 64'h201, 1'b1, 5'd11, 64'h101);
    step(1'b1, 5'd22, 64'h202, 1'b1, 5'd12, 64'h102);
    step(1'b1, 5'd23, 64'h203, 1'b0, 5'd0, 64'd0);
    step(1'b1, 5'd24, 64'h204, 1'b0, 5'd0, 64'd0);
    for (int i = 0; i < 4; i++) idle();

    // Same destination: load value lands first, buffered ALU value last.
    step(1'b1, 5'd9, 64'h2, 1'b1, 5'd8, 64'h5);
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h1);
    idle();
    idle();

    // Fill the buffer with two entries, then reset mid-drain.
    step(1'b1, 5'd2, 64'h22, 1'b1, 5'd1, 64'h21);
    step(1'b1, 5'd4, 64'h44, 1'b1, 5'd3, 64'h43);
    do_reset();
    for (int i = 0; i < 3; i++) idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
